ms_pwm_deadtime: RTL



---
 rtl/ms_pwm_deadtime_pkg.sv | 21 ++
 rtl/ms_dt_counter.sv | 32 +++
 rtl/ms_pwm_deadtime.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ms_pwm_deadtime_pkg.sv
// Shared types and constants for the dead-time generator.
// States use one-hot encoding so each output decode reads a single state bit.
package ms_pwm_deadtime_pkg;

  localparam int DT_W_DEFAULT = 8;

  localparam logic [4:0] ST_OFF   = 5'b00001;
  localparam logic [4:0] ST_LS_ON = 5'b00010;
  localparam logic [4:0] ST_DT_R  = 5'b00100;
  localparam logic [4:0] ST_HS_ON = 5'b01000;
  localparam logic [4:0] ST_DT_F  = 5'b10000;

  typedef enum logic [4:0] {
    OFF   = ST_OFF,
    LS_ON = ST_LS_ON,
    DT_R  = ST_DT_R,
    HS_ON = ST_HS_ON,
    DT_F  = ST_DT_F
  } state_t;

endpackage

// File: rtl/ms_dt_counter.sv
// Loadable down-counter that times one dead-time interval.
// The count rests at zero; the zero flag tells the FSM when the interval has expired.
module ms_dt_counter
  import ms_pwm_deadtime_pkg::*;
#(
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [DT_W-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  localparam logic [DT_W-1:0] ONE = 1;

  logic [DT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ms_pwm_deadtime.sv
// Turns a single-ended PWM into a complementary high/low gate-drive pair with dead-time.
// Pulses that end inside a dead-time are swallowed and reported on short_pulse.
module ms_pwm_deadtime
  import ms_pwm_deadtime_pkg::*;
#(
  parameter int DT_W         = DT_W_DEFAULT,
  parameter bit H_ACTIVE_LOW = 1'b0,
  parameter bit L_ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_rise,
  input  logic [DT_W-1:0] dt_fall,
  output logic            pwm_h,
  output logic            pwm_l,
  output logic            busy,
  output logic            short_pulse
);

  localparam logic [DT_W-1:0] ONE = 1;

  state_t          state;
  state_t          state_nxt;
  logic            pwm_q;
  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_zero;
  logic [DT_W-1:0] cnt_load_val;
  logic            swallow;

  // A dead-time of zero still costs one cycle when entered, hence the clamp.
  function automatic logic [DT_W-1:0] dt_minus_one(input logic [DT_W-1:0] dt);
    return (dt == '0) ? '0 : dt - ONE;
  endfunction

  ms_dt_counter #(
    .DT_W(DT_W)
  ) u_dt_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    swallow      = 1'b0;
    if (!en) begin
      state_nxt = OFF;
    end else begin
      unique case (state)
        OFF: begin
          cnt_load = 1'b1;
          if (pwm_q) begin
            state_nxt    = DT_R;
            cnt_load_val = dt_minus_one(dt_rise);
          end else begin
            state_nxt    = DT_F;
            cnt_load_val = dt_minus_one(dt_fall);
          end
        end
        LS_ON: begin
          if (pwm_q) begin
            if (dt_rise == '0) begin
              state_nxt = HS_ON;
            end else begin
              state_nxt    = DT_R;
              cnt_load     = 1'b1;
              cnt_load_val = dt_minus_one(dt_rise);
            end
          end
        end
        HS_ON: begin
          if (!pwm_q) begin
            if (dt_fall == '0) begin
              state_nxt = LS_ON;
            end else begin
              state_nxt    = DT_F;
              cnt_load     = 1'b1;
              cnt_load_val = dt_minus_one(dt_fall);
            end
          end
        end
        // Input reverting inside the dead-time wins over counter expiry.
        DT_R: begin
          if (!pwm_q) begin
            state_nxt = LS_ON;
            swallow   = 1'b1;
          end else if (cnt_zero) begin
            state_nxt = HS_ON;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        DT_F: begin
          if (pwm_q) begin
            state_nxt = HS_ON;
            swallow   = 1'b1;
          end else if (cnt_zero) begin
            state_nxt = LS_ON;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_nxt = OFF;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= OFF;
      pwm_q       <= 1'b0;
      pwm_h       <= H_ACTIVE_LOW;
      pwm_l       <= L_ACTIVE_LOW;
      busy        <= 1'b0;
      short_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      pwm_q       <= pwm_in;
      pwm_h       <= (state_nxt == HS_ON) ^ H_ACTIVE_LOW;
      pwm_l       <= (state_nxt == LS_ON) ^ L_ACTIVE_LOW;
      busy        <= (state_nxt == DT_R) || (state_nxt == DT_F);
      short_pulse <= swallow;
    end
  end

endmodule
